shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 130 +++++++++++++
 tb/tb_shift_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle controller that drives an external, combinational single-step
//   shifter to perform N-bit shifts. On a start request in IDLE it latches the
//   operand, op and amount. It then issues one shifter step per clock, feeding
//   each shifter result back as the next shifter operand. The final value is
//   registered in dout, and a one-cycle done pulse marks it valid.
//
//   Optional build macro SHIFT_SEQ_EARLY_EXIT_EN: when defined, RUN stops as
//   soon as further steps cannot change the accumulator. That happens when acc
//   is zero for op 01/10, or when acc is all zeros or all ones for op 11.
//   Results are identical in both builds; only latency differs.
//
// Handshake: start is a single-cycle request, honoured only while busy=0
//   (IDLE). Requests while busy, including the DONE cycle, are dropped. done is
//   a one-cycle pulse; dout stays valid until the next done.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   start      request, sampled only in IDLE
//   op[1:0]    00 pass, 01 left, 10 logical right, 11 arithmetic right
//   amount     number of single-bit steps
//   din        operand
//   shift      shifter control (00 unless a step is issued this cycle)
//   shift_in   shifter operand (always the accumulator)
//   sout       shifter result (combinational return)
//   busy       high whenever state is not IDLE
//   done       one-cycle pulse, result valid
//   dout       result register
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       shift,
  output logic [WIDTH-1:0] shift_in,
  input  logic [WIDTH-1:0] sout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [AMT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       op_r, op_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             settled;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  // Further steps are no-ops once the fill bits have taken over the whole word.
  always_comb begin
    settled = 1'b0;
    case (op_r)
      2'b01, 2'b10: settled = (acc == '0);
      2'b11:        settled = (acc == '0) || (acc == '1);
      default:      settled = 1'b0;
    endcase
  end
`else
  assign settled = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_r  <= 2'b00;
      dout  <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      op_r  <= op_nxt;
      dout  <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    op_nxt    = op_r;
    dout_nxt  = dout;
    shift     = 2'b00;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = din;
          op_nxt    = op;
          // A pass op needs no steps regardless of the requested amount.
          cnt_nxt   = (op == 2'b00) ? '0 : amount;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt != '0 && !settled) begin
          shift   = op_r;
          acc_nxt = sout;
          cnt_nxt = cnt - AMT_W'(1);
        end else begin
          dout_nxt  = acc;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign shift_in  = acc;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural single-step shifter.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [3:0]  amount = 4'd0;
  logic [15:0] din = 16'h0000;
  logic [1:0]  shift;
  logic [15:0] shift_in;
  logic [15:0] sout;
  logic        busy;
  logic        done;
  logic [15:0] dout;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .amount(amount),
    .din(din), .shift(shift), .shift_in(shift_in), .sout(sout),
    .busy(busy), .done(done), .dout(dout), .state_dbg(state_dbg)
  );

  // External single-step shifter
  always_comb begin
    case (shift)
      2'b01:   sout = {shift_in[14:0], 1'b0};
      2'b10:   sout = {1'b0, shift_in[15:1]};
      2'b11:   sout = {shift_in[15], shift_in[15:1]};
      default: sout = shift_in;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one request and follows it to done (bounded at 40 edges).
  // poke keeps start asserted with junk operands while busy.
  task automatic run_op(input string name, input logic [15:0] d, input logic [1:0] o,
                        input logic [3:0] a, input logic [15:0] exp_dout,
                        input int exp_lat, input int exp_steps, input bit poke);
    int n, lat, steps;
    bit seen, shift_ok;
    logic [15:0] exp_v, held;
    @(negedge clk);
    din = d; op = o; amount = a; start = 1'b1;
    exp_q.push_back(exp_dout);
    n = 0; lat = 0; steps = 0; seen = 0; shift_ok = 1;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (poke) begin
        start = 1'b1; din = 16'hAAAA; op = 2'b00; amount = 4'd0;
      end else begin
        start = 1'b0;
      end
      if (shift != 2'b00) begin
        steps++;
        if (shift != o) shift_ok = 0;
      end
      if (done) begin
        seen = 1;
        lat = n;
      end
    end
    start = 1'b0;
    exp_v = exp_q.pop_front();
    check({name, " latency"}, lat, exp_lat);
    check({name, " steps"}, steps, exp_steps);
    check({name, " shift code"}, {31'd0, shift_ok}, 32'd1);
    check({name, " dout"}, {16'd0, dout}, {16'd0, exp_v});
    held = dout;
    @(posedge clk); #1;
    check({name, " done pulse"}, {31'd0, done}, 32'd0);
    check({name, " busy after"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check({name, " dout hold"}, {16'd0, dout}, {16'd0, held});
  endtask

  initial begin
    int dones;
    // 1. reset with start asserted
    rst_n = 1'b0; start = 1'b1; din = 16'h5555; op = 2'b01; amount = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst dout", {16'd0, dout}, 32'h0);
    check("rst shift", {30'd0, shift}, 32'd0);
    check("rst shift_in", {16'd0, shift_in}, 32'h0);
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle after rst", {30'd0, state_dbg}, 32'd0);

    // 2. shift left
    run_op("shl3", 16'h8001, 2'b01, 4'd3, 16'h0008, 5, 3, 0);
    // 3. arithmetic and logical right
    run_op("sra4", 16'h8000, 2'b11, 4'd4, 16'hF800, 6, 4, 0);
    run_op("srl4", 16'h8000, 2'b10, 4'd4, 16'h0800, 6, 4, 0);
    // 4. zero amount and pass op
    run_op("srl0", 16'h1234, 2'b10, 4'd0, 16'h1234, 2, 0, 0);
    run_op("pass7", 16'h1234, 2'b00, 4'd7, 16'h1234, 2, 0, 0);
    // 5. requests while busy are ignored
    run_op("shl5 poke", 16'h00FF, 2'b01, 4'd5, 16'h1FE0, 7, 5, 1);

    // 5b. reset abort on the second RUN cycle
    @(negedge clk);
    din = 16'h00FF; op = 2'b01; amount = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort in run", {30'd0, state_dbg}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort dout", {16'd0, dout}, 32'h0);
    check("abort shift_in", {16'd0, shift_in}, 32'h0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort no done", dones, 0);

    // 6. early-exit candidates
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    run_op("srl15 early", 16'h0001, 2'b10, 4'd15, 16'h0000, 3, 1, 0);
    run_op("sra9 ones", 16'hFFFF, 2'b11, 4'd9, 16'hFFFF, 2, 0, 0);
`else
    run_op("srl15 full", 16'h0001, 2'b10, 4'd15, 16'h0000, 17, 15, 0);
    run_op("sra9 ones", 16'hFFFF, 2'b11, 4'd9, 16'hFFFF, 11, 9, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
